// File: rtl/cpu_hart_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_hart_boot_ctrl
// Brief    : Per-hart boot address / fetch-enable controller with staggered
//            release, sleep-gated shutdown and a 32-bit OBI register port.
//            Optional macro CPU_HART_BOOT_CTRL_SLEEP_CNT_EN adds per-hart
//            sleep-cycle counters at 0x40+4h.
// Revision : 1.0 - initial release
// ============================================================================

package cpu_hart_boot_ctrl_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module cpu_hart_boot_ctrl
    import cpu_hart_boot_ctrl_pkg::*;
#(
    parameter int                   NUM_HARTS      = 2,
    parameter logic [31:0]          BOOT_ADDR      = 32'h180,
    parameter logic [NUM_HARTS-1:0] BOOT_EN_MASK   = 'b1,
    parameter int                   STAGGER_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  obi_req_t                reg_req_i,
    output obi_resp_t               reg_resp_o,
    input  logic [NUM_HARTS-1:0]    core_sleep_i,
    output logic [NUM_HARTS-1:0]    fetch_enable_o,
    output logic [NUM_HARTS*32-1:0] boot_addr_o
);

    localparam int c_ptr_w = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int c_cnt_w = $clog2(STAGGER_CYCLES + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(NUM_HARTS - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(STAGGER_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [0:0] c_st_release = 1'b0;
    localparam logic [0:0] c_st_run     = 1'b1;

    logic [0:0]              r_state, w_state_nxt;
    logic [c_ptr_w-1:0]      r_ptr, w_ptr_nxt;
    logic [c_cnt_w-1:0]      r_cnt, w_cnt_nxt;
    logic [NUM_HARTS-1:0]    r_run;
    logic [NUM_HARTS-1:0]    r_fe;
    logic [NUM_HARTS-1:0]    w_pending;
    logic [NUM_HARTS-1:0]    w_rel_set;
    logic [NUM_HARTS-1:0]    w_disable;
    logic                    w_adv;
    logic                    w_wr;
    logic                    w_rd;
    logic [5:0]              w_idx;
    logic [31:0]             w_rdata;
    logic [31:0]             r_rdata;
    logic                    r_rvalid;
    logic [NUM_HARTS*32-1:0] w_boot;
`ifdef CPU_HART_BOOT_CTRL_SLEEP_CNT_EN
    logic [NUM_HARTS*32-1:0] w_scnt;
`endif
    logic                    w_unused;

    assign w_wr      = reg_req_i.req &  reg_req_i.we;
    assign w_rd      = reg_req_i.req & ~reg_req_i.we;
    assign w_idx     = reg_req_i.addr[7:2];
    assign w_pending = r_run & ~r_fe;
    assign w_disable = ~r_run & core_sleep_i;
    assign w_unused  = &{1'b0, reg_req_i.addr[31:8], reg_req_i.addr[1:0]};

    // Skips of idle harts overlap the stagger wait; only a real release
    // has to wait for the counter to drain.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - c_cnt_one) : r_cnt;
        w_rel_set   = '0;
        w_adv       = 1'b0;
        if (r_state == c_st_release) begin
            if (w_pending[r_ptr]) begin
                if (r_cnt == '0) begin
                    w_rel_set[r_ptr] = 1'b1;
                    w_cnt_nxt        = c_cnt_load;
                    w_adv            = 1'b1;
                end
            end else begin
                w_adv = 1'b1;
            end
            if (w_adv) begin
                if (r_ptr == c_ptr_last) begin
                    w_state_nxt = c_st_run;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + c_ptr_one;
                end
            end
        end else if (|w_pending) begin
            w_state_nxt = c_st_release;
            w_ptr_nxt   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_st_release;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_fe    <= '0;
            r_run   <= BOOT_EN_MASK;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fe    <= (r_fe | w_rel_set) & ~w_disable;
            if (w_wr && (w_idx == 6'd0) && reg_req_i.be[0]) begin
                r_run <= reg_req_i.wdata[NUM_HARTS-1:0];
            end
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic [31:2] r_boot;

        // Boot address is frozen while the hart is fetching.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_boot <= BOOT_ADDR[31:2];
            end else if (w_wr && (w_idx == 6'(2 + h)) && !r_fe[h]) begin
                if (reg_req_i.be[0]) r_boot[7:2]   <= reg_req_i.wdata[7:2];
                if (reg_req_i.be[1]) r_boot[15:8]  <= reg_req_i.wdata[15:8];
                if (reg_req_i.be[2]) r_boot[23:16] <= reg_req_i.wdata[23:16];
                if (reg_req_i.be[3]) r_boot[31:24] <= reg_req_i.wdata[31:24];
            end
        end

        assign w_boot[32*h +: 32] = {r_boot, 2'b00};

`ifdef CPU_HART_BOOT_CTRL_SLEEP_CNT_EN
        logic [31:0] r_scnt;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_scnt <= '0;
            end else if (w_wr && (w_idx == 6'(16 + h))) begin
                r_scnt <= '0;
            end else if (core_sleep_i[h] && (r_scnt != 32'hFFFF_FFFF)) begin
                r_scnt <= r_scnt + 32'd1;
            end
        end

        assign w_scnt[32*h +: 32] = r_scnt;
`endif
    end

    always_comb begin
        w_rdata = '0;
        if (w_idx == 6'd0) begin
            w_rdata[NUM_HARTS-1:0] = r_run;
        end else if (w_idx == 6'd1) begin
            w_rdata[NUM_HARTS-1:0]     = r_fe;
            w_rdata[16 +: NUM_HARTS]   = core_sleep_i;
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_idx == 6'(2 + h)) begin
                w_rdata = w_boot[32*h +: 32];
            end
`ifdef CPU_HART_BOOT_CTRL_SLEEP_CNT_EN
            if (w_idx == 6'(16 + h)) begin
                w_rdata = w_scnt[32*h +: 32];
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= reg_req_i.req;
            r_rdata  <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign reg_resp_o.gnt    = reg_req_i.req;
    assign reg_resp_o.rvalid = r_rvalid;
    assign reg_resp_o.rdata  = r_rdata;
    assign fetch_enable_o    = r_fe;
    assign boot_addr_o       = w_boot;

endmodule

`default_nettype wire

// File: tb/tb_cpu_hart_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_hart_boot_ctrl
// Brief    : Self-checking bench for cpu_hart_boot_ctrl (4 harts, mask 0101,
//            stagger 4); honours CPU_HART_BOOT_CTRL_SLEEP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cpu_hart_boot_ctrl;
    import cpu_hart_boot_ctrl_pkg::*;

    localparam int NH = 4;
`ifdef CPU_HART_BOOT_CTRL_SLEEP_CNT_EN
    localparam logic [31:0] SLEEP_EXP = 32'd7;
`else
    localparam logic [31:0] SLEEP_EXP = 32'd0;
`endif

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    obi_req_t      req;
    obi_resp_t     resp;
    logic [NH-1:0] sleep;
    logic [NH-1:0] fe;
    logic [NH*32-1:0] boot;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [17];

    always #5 clk = ~clk;

    cpu_hart_boot_ctrl #(
        .NUM_HARTS      (NH),
        .BOOT_ADDR      (32'h180),
        .BOOT_EN_MASK   (4'b0101),
        .STAGGER_CYCLES (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reg_req_i      (req),
        .reg_resp_o     (resp),
        .core_sleep_i   (sleep),
        .fetch_enable_o (fe),
        .boot_addr_o    (boot)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic we, input logic [7:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        req.req   = 1'b1;
        req.we    = we;
        req.addr  = {24'h0, addr};
        req.be    = be;
        req.wdata = wdata;
        #1;
        check("gnt", resp.gnt, 1'b1);
        @(posedge clk);
        #1;
        req = '0;
        check("rvalid", resp.rvalid, 1'b1);
        rdata = resp.rdata;
    endtask

    task automatic release_seq(input string tag);
        logic [3:0] exp_fe [6];
        exp_fe = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0101};
        for (int e = 0; e < 6; e++) begin
            tick();
            check($sformatf("%s_edge%0d", tag, e + 1), fe, exp_fe[e]);
        end
    endtask

    task automatic wait_fe(input int idx, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (fe[idx] === 1'b1) break;
            tick();
        end
        check(name, fe[idx], 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b0, 8'h00, 4'hF, 32'h0,         32'h0000_0005};
        vecs[1]  = '{1'b0, 8'h04, 4'hF, 32'h0,         32'h0000_0005};
        vecs[2]  = '{1'b0, 8'h08, 4'hF, 32'h0,         32'h0000_0180};
        vecs[3]  = '{1'b0, 8'h14, 4'hF, 32'h0,         32'h0000_0180};
        vecs[4]  = '{1'b1, 8'h0C, 4'hF, 32'h2000_0003, 32'h0};
        vecs[5]  = '{1'b0, 8'h0C, 4'hF, 32'h0,         32'h2000_0000};
        vecs[6]  = '{1'b1, 8'h14, 4'h2, 32'hAABB_CCDD, 32'h0};
        vecs[7]  = '{1'b0, 8'h14, 4'hF, 32'h0,         32'h0000_CC80};
        vecs[8]  = '{1'b1, 8'h08, 4'hF, 32'h1234_0000, 32'h0};
        vecs[9]  = '{1'b0, 8'h08, 4'hF, 32'h0,         32'h0000_0180};
        vecs[10] = '{1'b1, 8'h00, 4'h0, 32'h0000_000F, 32'h0};
        vecs[11] = '{1'b0, 8'h00, 4'hF, 32'h0,         32'h0000_0005};
        vecs[12] = '{1'b1, 8'h30, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b0, 8'h30, 4'hF, 32'h0,         32'h0};
        vecs[14] = '{1'b0, 8'h18, 4'hF, 32'h0,         32'h0};
        vecs[15] = '{1'b0, 8'h44, 4'hF, 32'h0,         32'h0};
        vecs[16] = '{1'b0, 8'h04, 4'hF, 32'h0,         32'h0000_0005};

        req   = '0;
        sleep = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_fe", fe, 4'b0000);
        check("rst_boot", boot, {4{32'h0000_0180}});
        check("rst_rvalid", resp.rvalid, 1'b0);
        check("rst_rdata", resp.rdata, 32'h0);
        rst_n = 1'b1;

        release_seq("release");
        check("boot_after_release", boot, {4{32'h0000_0180}});

        for (int i = 0; i < 17; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end
        tick();
        check("rvalid_idle", resp.rvalid, 1'b0);
        check("boot_port_h1", boot[63:32], 32'h2000_0000);
        check("boot_port_h3", boot[127:96], 32'h0000_CC80);
        check("boot_port_h0", boot[31:0], 32'h0000_0180);

        bus(1'b1, 8'h00, 4'h1, 32'h7, rd);
        wait_fe(1, 20, "hart1_release");
        check("fe_after_run7", fe, 4'b0111);

        bus(1'b1, 8'h00, 4'h1, 32'h0, rd);
        bus(1'b0, 8'h04, 4'hF, 32'h0, rd);
        check("status_pending", rd, 32'h0000_0007);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("fe0_pending%0d", i), fe[0], 1'b1);
        end
        sleep[0] = 1'b1;
        tick();
        check("fe0_cleared", fe[0], 1'b0);
        bus(1'b0, 8'h04, 4'hF, 32'h0, rd);
        check("status_after_sleep", rd, 32'h0001_0006);

        sleep[1] = 1'b1;
        repeat (7) tick();
        sleep[1] = 1'b0;
        bus(1'b0, 8'h44, 4'hF, 32'h0, rd);
        check("sleep_cnt_7", rd, SLEEP_EXP);
        sleep[1] = 1'b1;
        bus(1'b1, 8'h44, 4'hF, 32'h0, rd);
        sleep[1] = 1'b0;
        bus(1'b0, 8'h44, 4'hF, 32'h0, rd);
        check("sleep_cnt_clr", rd, 32'h0);

        sleep = '0;
        bus(1'b1, 8'h00, 4'h1, 32'h3, rd);
        wait_fe(0, 20, "hart0_rerelease");
        req.req  = 1'b1;
        req.addr = 32'h0;
        req.be   = 4'hF;
        @(posedge clk);
        #1;
        req = '0;
        check("inflight_rvalid", resp.rvalid, 1'b1);
        check("fe_in_wait", fe, 4'b0101);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_fe", fe, 4'b0000);
        check("async_rst_boot", boot, {4{32'h0000_0180}});
        check("async_rst_rvalid", resp.rvalid, 1'b0);
        check("async_rst_rdata", resp.rdata, 32'h0);
        repeat (2) tick();
        check("held_rst_fe", fe, 4'b0000);
        rst_n = 1'b1;
        release_seq("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_hart_boot_ctrl.md
Name: cpu_hart_boot_ctrl

Overview:
- Parametrised boot and fetch-enable controller for a multi-hart CPU subsystem; replaces the hard-wired fetch_enable=1 and fixed boot address of the single-core subsystem.
- Holds a per-hart boot address and run request, and releases harts in a staggered sequence.
- Gates hart shutdown on core sleep.
- Programmed through a 32-bit OBI slave port on the peripheral bus.

Parameters:
- NUM_HARTS, 2, number of harts controlled (1..8).
- BOOT_ADDR, 32'h180, reset value of every BOOT_ADDR register.
- BOOT_EN_MASK, 'b1, reset value of CTRL.run (NUM_HARTS bits); harts set here auto-release after reset.
- STAGGER_CYCLES, 4, cycles between successive hart releases (>=1). Counter width is $clog2(STAGGER_CYCLES+1).

Ports:
- clk_i, input, 1, clock.
- rst_ni, input, 1, reset.
- reg_req_i, input, obi_req_t, OBI register request (addr, we, be, wdata, req).
- reg_resp_o, output, obi_resp_t, OBI register response (gnt, rvalid, rdata).
- core_sleep_i, input, NUM_HARTS, per-hart core_sleep_o.
- fetch_enable_o, output, NUM_HARTS, per-hart fetch enable.
- boot_addr_o, output, NUM_HARTS*32, per-hart boot address; hart h occupies bits [32h+31:32h].

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - fetch_enable_o = 0; boot_addr_o = BOOT_ADDR for all harts, with bits [1:0] forced to 0.
  - rvalid = 0, rdata = 0, CTRL.run = BOOT_EN_MASK.
  - FSM = RELEASE, ptr = 0, stagger counter = 0.
- OBI slave:
  - gnt = req, combinational; every request is accepted.
  - rvalid is asserted exactly 1 cycle after a granted request and carries rdata for reads (0 for writes).
  - Writes honour be per byte.
- Register map (addr[7:2]):
  - 0x00 CTRL: RW; bits [NUM_HARTS-1:0] = run.
  - 0x04 STATUS: RO; [NUM_HARTS-1:0] = fetch_enable_o; [16+NUM_HARTS-1:16] = core_sleep_i.
  - 0x08+4h BOOT_ADDR[h]: RW; bits [1:0] read 0.
  - All other addresses: reads return 0, writes are ignored.
- BOOT_ADDR[h] write lock: a write while fetch_enable_o[h]=1 is ignored, no error.
- FSM states RELEASE and RUN:
  - RELEASE, evaluated each cycle at hart ptr:
    - run[ptr]=1 and fetch_enable_o[ptr]=0: set fetch_enable_o[ptr] (registered), load counter = STAGGER_CYCLES-1. Count down to 0, then ptr++.
    - Otherwise: ptr++ next cycle, no wait.
    - After ptr = NUM_HARTS-1 has been processed: go to RUN.
  - RUN: if any hart has run=1 and fetch_enable_o=0, go to RELEASE with ptr=0.
- Release timing:
  - After reset release, hart 0 (if run[0]=1) sees fetch_enable_o rise at the first clock edge.
  - Hart h+1 rises STAGGER_CYCLES cycles after hart h.
- Disable:
  - fetch_enable_o[h] clears on the first edge where run[h]=0 and core_sleep_i[h]=1; this is checked in any FSM state.
  - Until then the disable stays pending and STATUS still shows 1.
- Simultaneous events:
  - A CTRL write in the same cycle as a release decision takes effect the next cycle.
  - Clearing run[ptr] during its stagger wait does not shorten the wait.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); an in-flight rvalid is dropped.

Optional Feature:
- Macro: CPU_HART_BOOT_CTRL_SLEEP_CNT_EN.
- Defined:
  - Per-hart 32-bit sleep counter at 0x40+4h, RO.
  - Increments each cycle core_sleep_i[h]=1 and saturates at 32'hFFFFFFFF.
  - Any write to the address clears it to 0; the write takes priority over an increment in the same cycle.
  - Reset value is 0.
- Undefined: no counters; 0x40+4h reads 0 and writes are ignored.

Test Plan:
- Reset with NUM_HARTS=4, BOOT_EN_MASK=4'b0101, STAGGER_CYCLES=4 -> fetch_enable_o[0] rises at edge 1 and fetch_enable_o[2] at edge 5; harts 1 and 3 stay 0; boot_addr_o = 32'h180 for every hart.
- Write BOOT_ADDR[1]=32'h2000_0003 with be=4'hF, then CTRL=4'b0111 -> readback of BOOT_ADDR[1] = 32'h2000_0000; fetch_enable_o[1] rises; rvalid arrives 1 cycle after each gnt.
- With hart 0 running, write CTRL=0 while core_sleep_i[0]=0 for 10 cycles, then drive core_sleep_i[0]=1 -> fetch_enable_o[0] stays 1 for the 10 cycles and clears on the first sleep edge; STATUS[0] tracks it.
- Write BOOT_ADDR[0]=32'h1234_0000 while fetch_enable_o[0]=1 -> readback unchanged at 32'h180.
- Assert rst_ni low during a RELEASE stagger wait -> outputs return to reset values asynchronously and the release sequence restarts from hart 0.
- With CPU_HART_BOOT_CTRL_SLEEP_CNT_EN defined, hold core_sleep_i[1]=1 for 7 cycles -> 0x44 reads 7; a write to 0x44 coincident with sleep -> reads 0 next. Without the macro, 0x44 reads 0.
